// File: rtl/pc_sequencer.sv
// Program-counter stage: next-PC selection, exception freeze/EPC capture with resume,
// and a debounced LOAD key that loads the PC from the switches.
module pc_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter logic [7:0]  PC_RESET        = 8'h00
) (
  input  logic       SYS_clk,
  input  logic       SYS_rst,
  input  logic       PCS_load_n,
  input  logic [7:0] PCS_load_val,
  input  logic       PCS_branch,
  input  logic       PCS_zero,
  input  logic       PCS_jump,
  input  logic [7:0] PCS_br_off,
  input  logic [7:0] PCS_j_off,
  input  logic       PCS_eh_flag,
  input  logic       PCS_resume,
  output logic [7:0] PCS_pc,
  output logic [7:0] PCS_epc,
  output logic       PCS_halted,
  output logic       PCS_load_pulse
);

  localparam int unsigned CW      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_e;

  state_e        state_q;
  logic [7:0]    pc_q, epc_q;
  logic          load_pulse_q;
  logic          sync1_q, sync2_q, deb_q, deb_prev_q;
  logic [CW-1:0] cnt_q;
  logic [7:0]    seq_d, pc_d;
  logic          load_evt;

  // Jump outranks a taken branch; offsets are in words, modulo 256.
  always_comb begin
    seq_d = pc_q + 8'd1;
    pc_d  = seq_d;
    if (PCS_jump)                    pc_d = seq_d + PCS_j_off;
    else if (PCS_branch && PCS_zero) pc_d = seq_d + PCS_br_off;
  end

  // Press is the registered falling edge of the debounced level.
  assign load_evt = deb_prev_q & ~deb_q;

  always_ff @(posedge SYS_clk) begin
    if (SYS_rst) begin
      state_q      <= RUN;
      pc_q         <= PC_RESET;
      epc_q        <= 8'h00;
      load_pulse_q <= 1'b0;
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      deb_q        <= 1'b1;
      deb_prev_q   <= 1'b1;
      cnt_q        <= '0;
    end else begin
      sync1_q    <= PCS_load_n;
      sync2_q    <= sync1_q;
      deb_prev_q <= deb_q;
      if (sync2_q != deb_q) begin
        if (cnt_q == CNT_MAX) begin
          deb_q <= sync2_q;
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end else begin
        cnt_q <= '0;
      end

      load_pulse_q <= load_evt;
      if (load_evt) begin
        pc_q    <= PCS_load_val;
        state_q <= RUN;
      end else begin
        case (state_q)
          RUN: begin
            if (PCS_eh_flag) begin
              epc_q   <= pc_q;
              state_q <= HALT;
            end else begin
              pc_q <= pc_d;
            end
          end
          HALT: begin
            if (PCS_resume) begin
              pc_q    <= epc_q + 8'd1;
              state_q <= RUN;
            end
          end
          default: state_q <= RUN;
        endcase
      end
    end
  end

  assign PCS_pc         = pc_q;
  assign PCS_epc        = epc_q;
  assign PCS_halted     = (state_q == HALT);
  assign PCS_load_pulse = load_pulse_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer with default parameters.
module tb_pc_sequencer;

  logic       clk = 1'b0;
  logic       rst, load_n, branch, zero, jump, eh_flag, resume;
  logic [7:0] load_val, br_off, j_off;
  logic [7:0] pc, epc;
  logic       halted, load_pulse;
  int         pass_cnt = 0;
  int         total_cnt = 0;

  always #5 clk = ~clk;

  pc_sequencer #(.DEBOUNCE_CYCLES(16), .PC_RESET(8'h00)) dut (
    .SYS_clk(clk), .SYS_rst(rst), .PCS_load_n(load_n), .PCS_load_val(load_val),
    .PCS_branch(branch), .PCS_zero(zero), .PCS_jump(jump), .PCS_br_off(br_off),
    .PCS_j_off(j_off), .PCS_eh_flag(eh_flag), .PCS_resume(resume),
    .PCS_pc(pc), .PCS_epc(epc), .PCS_halted(halted), .PCS_load_pulse(load_pulse)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctrl();
    branch = 0; zero = 0; jump = 0; eh_flag = 0; resume = 0;
    br_off = 8'h00; j_off = 8'h00;
  endtask

  // Reset, then free-run n cycles so PC equals n.
  task automatic goto_pc(input int n);
    clear_ctrl();
    load_n = 1; rst = 1;
    tick();
    rst = 0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    clear_ctrl();
    load_n = 1; load_val = 8'h00; rst = 1;
    tick(); tick();
    total_cnt++;
    if (pc !== 8'h00 || epc !== 8'h00 || halted !== 1'b0 || load_pulse !== 1'b0)
      $display("FAIL reset pc=%h epc=%h halted=%b pulse=%b exp 00/00/0/0", pc, epc, halted, load_pulse);
    else pass_cnt++;
    rst = 0;
  endtask

  task automatic test_free_run();
    logic [7:0] exp;
    int bad;
    bad = 0;
    for (int i = 1; i <= 256; i++) begin
      tick();
      exp = 8'(i);
      if (pc !== exp || halted !== 1'b0) begin
        if (bad < 4) $display("FAIL free_run step %0d pc=%h halted=%b exp %h/0", i, pc, halted, exp);
        bad++;
      end
    end
    total_cnt++;
    if (bad == 0) pass_cnt++;
    total_cnt++;
    if (pc !== 8'h00) $display("FAIL wrap pc=%h exp 00", pc);
    else pass_cnt++;
  endtask

  task automatic test_branch_jump();
    goto_pc(16);
    branch = 1; zero = 1; br_off = 8'hFC;
    tick();
    total_cnt++;
    if (pc !== 8'h0D) $display("FAIL br_taken pc=%h exp 0D", pc);
    else pass_cnt++;
    goto_pc(16);
    branch = 1; zero = 0; br_off = 8'hFC;
    tick();
    total_cnt++;
    if (pc !== 8'h11) $display("FAIL br_not_taken pc=%h exp 11", pc);
    else pass_cnt++;
    goto_pc(16);
    branch = 1; zero = 1; br_off = 8'hFC; jump = 1; j_off = 8'h05;
    tick();
    total_cnt++;
    if (pc !== 8'h16) $display("FAIL jump_priority pc=%h exp 16", pc);
    else pass_cnt++;
    clear_ctrl();
  endtask

  task automatic test_exception();
    int bad;
    goto_pc(32);
    eh_flag = 1; jump = 1; j_off = 8'h40;
    tick();
    total_cnt++;
    if (pc !== 8'h20 || epc !== 8'h20 || halted !== 1'b1)
      $display("FAIL exc_capture pc=%h epc=%h halted=%b exp 20/20/1", pc, epc, halted);
    else pass_cnt++;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      jump = ~jump; eh_flag = (i % 3 == 0);
      tick();
      if (pc !== 8'h20 || halted !== 1'b1 || epc !== 8'h20) bad++;
    end
    total_cnt++;
    if (bad != 0) $display("FAIL halt_hold bad=%0d pc=%h halted=%b exp 20/1", bad, pc, halted);
    else pass_cnt++;
    clear_ctrl();
    resume = 1;
    tick();
    total_cnt++;
    if (pc !== 8'h21 || halted !== 1'b0) $display("FAIL resume pc=%h halted=%b exp 21/0", pc, halted);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (pc !== 8'h22 || halted !== 1'b0) $display("FAIL resume_in_run pc=%h halted=%b exp 22/0", pc, halted);
    else pass_cnt++;
    clear_ctrl();
    goto_pc(255);
    eh_flag = 1;
    tick();
    eh_flag = 0; resume = 1;
    tick();
    total_cnt++;
    if (pc !== 8'h00 || epc !== 8'hFF || halted !== 1'b0)
      $display("FAIL resume_wrap pc=%h epc=%h halted=%b exp 00/FF/0", pc, epc, halted);
    else pass_cnt++;
    clear_ctrl();
  endtask

  task automatic test_debounce();
    int pulses, pulse_at;
    logic [7:0] pc_at;
    goto_pc(0);
    load_val = 8'h5A;
    pulses = 0;
    load_n = 0;
    for (int i = 0; i < 10; i++) begin tick(); if (load_pulse) pulses++; end
    load_n = 1;
    for (int i = 0; i < 3; i++) begin tick(); if (load_pulse) pulses++; end
    total_cnt++;
    if (pulses != 0) $display("FAIL bounce_no_load pulses=%0d exp 0", pulses);
    else pass_cnt++;
    load_n = 0;
    pulse_at = -1; pc_at = 8'h00;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (load_pulse) begin pulses++; if (pulse_at < 0) begin pulse_at = i; pc_at = pc; end end
    end
    load_n = 1;
    for (int i = 0; i < 25; i++) begin tick(); if (load_pulse) pulses++; end
    total_cnt++;
    if (pulses != 1) $display("FAIL one_load pulses=%0d exp 1", pulses);
    else pass_cnt++;
    total_cnt++;
    if (pulse_at != 19 || pc_at !== 8'h5A)
      $display("FAIL load_latency cycle=%0d pc=%h exp 19/5A", pulse_at, pc_at);
    else pass_cnt++;
    total_cnt++;
    if (pc !== 8'h5A + 8'd21 + 8'd25) $display("FAIL post_load_run pc=%h exp %h", pc, 8'h5A + 8'd46);
    else pass_cnt++;
  endtask

  task automatic test_load_in_halt();
    int bad;
    goto_pc(7);
    eh_flag = 1;
    tick();
    eh_flag = 0;
    load_val = 8'hC3; load_n = 0;
    bad = 0;
    for (int i = 1; i <= 18; i++) begin
      tick();
      if (pc !== 8'h07 || halted !== 1'b1 || load_pulse !== 1'b0) bad++;
    end
    total_cnt++;
    if (bad != 0) $display("FAIL halt_before_load bad=%0d pc=%h halted=%b", bad, pc, halted);
    else pass_cnt++;
    resume = 1;
    tick();
    resume = 0;
    total_cnt++;
    if (pc !== 8'hC3 || halted !== 1'b0 || epc !== 8'h07 || load_pulse !== 1'b1)
      $display("FAIL load_in_halt pc=%h halted=%b epc=%h pulse=%b exp C3/0/07/1", pc, halted, epc, load_pulse);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (pc !== 8'hC4 || load_pulse !== 1'b0) $display("FAIL after_load pc=%h pulse=%b exp C4/0", pc, load_pulse);
    else pass_cnt++;
    load_n = 1;
  endtask

  task automatic test_reset_mid();
    int pulses, bad;
    goto_pc(0);
    load_val = 8'h99; load_n = 0;
    for (int i = 0; i < 10; i++) tick();
    load_n = 1; rst = 1;
    tick();
    total_cnt++;
    if (pc !== 8'h00 || epc !== 8'h00 || halted !== 1'b0 || load_pulse !== 1'b0)
      $display("FAIL rst_mid_debounce pc=%h epc=%h halted=%b pulse=%b", pc, epc, halted, load_pulse);
    else pass_cnt++;
    rst = 0;
    pulses = 0; bad = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (load_pulse) pulses++;
      if (pc !== 8'(i)) bad++;
    end
    total_cnt++;
    if (pulses != 0 || bad != 0) $display("FAIL rst_no_load pulses=%0d bad=%0d exp 0/0", pulses, bad);
    else pass_cnt++;
    goto_pc(5);
    eh_flag = 1;
    tick();
    eh_flag = 0; rst = 1;
    tick();
    total_cnt++;
    if (pc !== 8'h00 || epc !== 8'h00 || halted !== 1'b0)
      $display("FAIL rst_in_halt pc=%h epc=%h halted=%b exp 00/00/0", pc, epc, halted);
    else pass_cnt++;
    rst = 0;
    tick();
    total_cnt++;
    if (pc !== 8'h01 || halted !== 1'b0) $display("FAIL restart pc=%h halted=%b exp 01/0", pc, halted);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_branch_jump();
    test_exception();
    test_debounce();
    test_load_in_halt();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
